multicycle_controller: RTL and testbench

Sequencing controller for the multicycle ARM core. It replaces the single-cycle decode path with a registered state machine that steps one shared ALU, one unified memory port and the register file through fetch, decode, execute, memory and writeback. It holds the condition flags and a registered condition-pass bit, and it drives every datapath select and write enable for each step.

---
 rtl/mc_ctrl_pkg.sv | 88 ++++++++
 rtl/mc_cond_unit.sv | 37 +++
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM sequencing controller.
// Latency: n/a (types, constants and the condition-check helper only).
// Backpressure: n/a.
//
// Contents: state encoding, ALU operation codes, ALU B and result mux
// encodings, ARM condition codes and the CondEx helper function.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_LINK   = 4'd10
  } state_t;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  // ALU B operand select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Register-file result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_PC        = 2'b11;

  // Flag write masks, bit order {N,Z,C,V}
  localparam logic [3:0] FLAGS_ALL = 4'b1111;
  localparam logic [3:0] FLAGS_NZ  = 4'b1100;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Condition check against stored {N,Z,C,V}; the NV slot never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      COND_NV: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Condition unit: evaluates CondEx from stored flags and holds the flags and cond_q.
// Latency: cond_q and flags update one clock after their load strobes.
// Backpressure: none; loads happen whenever the strobes are high.
//
// Ports: clk, rst_n (async active-low); cond (instr [31:28]); alu_flags {N,Z,C,V};
// cond_load (latch CondEx); flag_load + flag_mask (per-bit flag write); flags, cond_q out.
module mc_cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_load,
  input  logic       flag_load,
  input  logic [3:0] flag_mask,
  output logic [3:0] flags,
  output logic       cond_q
);

  logic [3:0] wr_mask;

  assign wr_mask = flag_load ? flag_mask : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 4'b0000;
      cond_q <= 1'b0;
    end else begin
      flags <= (flags & ~wr_mask) | (alu_flags & wr_mask);
      if (cond_load) begin
        cond_q <= cond_pass(cond, flags);
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM sequencer: steps shared ALU, memory port and regfile per instruction.
// Latency: DP 4, LDR 5, STR 4, B 3, BL 4 (MC_CTRL_BL_EN), Op=11 2 cycles.
// Backpressure: none; the sequence advances every clock, write enables forced low in reset.
//
// Ports: clk, rst_n; instruction fields Cond/Op/Funct/Rd; ALUFlags from the ALU;
// write enables PCWrite/IRWrite/RegWrite/MemWrite; mux selects AdrSrc, ALUSrcA, ALUSrcB,
// ResultSrc, ImmSrc, RegSrc, LinkSel; ALUControl; stored Flags.
// Optional: define MC_CTRL_BL_EN to route BL through the LINK state (R14 <= PC+4).
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       LinkSel,
  output logic [3:0] Flags
);

  state_t     state_q, state_d;
  logic       cond_q;
  logic [2:0] dp_alu;
  logic       no_write;
  logic [3:0] dp_mask;
  logic       pc_write, ir_write, reg_write, mem_write;
  logic       flag_load;

  // Data-processing cmd decode
  always_comb begin
    dp_alu   = ALU_ADD;
    no_write = 1'b0;
    dp_mask  = FLAGS_ALL;
    case (Funct[4:1])
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: begin dp_alu = ALU_AND; dp_mask = FLAGS_NZ; end
      4'b1100: begin dp_alu = ALU_ORR; dp_mask = FLAGS_NZ; end
      4'b1101: begin dp_alu = ALU_MOV; dp_mask = FLAGS_NZ; end
      4'b1010: begin dp_alu = ALU_SUB; no_write = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  assign flag_load = ((state_q == S_EXECR) || (state_q == S_EXECI)) && Funct[0] && cond_q;

  mc_cond_unit u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .cond_load (state_q == S_DECODE),
    .flag_load (flag_load),
    .flag_mask (dp_mask),
    .flags     (Flags),
    .cond_q    (cond_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
`ifdef MC_CTRL_BL_EN
          2'b10:   state_d = Funct[4] ? S_LINK : S_BRANCH;
`else
          2'b10:   state_d = S_BRANCH;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
`ifdef MC_CTRL_BL_EN
      S_LINK:   state_d = S_BRANCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    ResultSrc  = RES_ALUOUT;
    LinkSel    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        reg_write = cond_q;
        pc_write  = cond_q && (Rd == 4'd15);
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = cond_q;
      end
      S_EXECR: ALUControl = dp_alu;
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dp_alu;
      end
      S_ALUWB: begin
        reg_write = cond_q && !no_write;
        pc_write  = cond_q && !no_write && (Rd == 4'd15);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_write  = cond_q;
      end
      S_LINK: begin
        ResultSrc = RES_PC;
        reg_write = cond_q;
`ifdef MC_CTRL_BL_EN
        LinkSel   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so nothing writes in the cycle reset lands.
  assign PCWrite  = pc_write  & rst_n;
  assign IRWrite  = ir_write  & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign MemWrite = mem_write & rst_n;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01) && !Funct[0], Op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; expected per-cycle output vectors are queued
// when an instruction is issued and popped/compared as the controller steps through it.
// Vector layout: {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, LinkSel}.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, LinkSel;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  int compared   = 0;
  int mismatched = 0;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .LinkSel(LinkSel), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ov(input logic [3:0] st, input logic pcw, input logic irw,
                                     input logic rw, input logic mw, input logic adr,
                                     input logic srca, input logic [1:0] srcb,
                                     input logic [2:0] alu, input logic [1:0] res,
                                     input logic link);
    return {st, pcw, irw, rw, mw, adr, srca, srcb, alu, res, link};
  endfunction

  task automatic push(input string tag, input logic [17:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_vec(input string tag, input logic [17:0] exp_v);
    logic [17:0] obs;
    obs = {dut.state_q, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ALUControl, ResultSrc, LinkSel};
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp_v);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Compare one queued vector per clock, sampling #3 after the rising edge.
  task automatic drain();
    while (exp_q.size() > 0) begin
      #2;
      check_vec(tag_q.pop_front(), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  // Present a new instruction during its FETCH cycle and queue FETCH + DECODE.
  task automatic start(input string name, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
    push({name, ".fetch"},  ov(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 3'b000, 2'b10, 0));
    push({name, ".decode"}, ov(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0));
  endtask

  logic [17:0] rst_v;

  initial begin
    rst_v = ov(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b10, 0);
    rst_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", rst_v);
    drain();
    check4("reset_flags", Flags, 4'b0000);
    rst_n = 1'b1;

    // ADD R1,R2,R3 (AL, S=0)
    start("add", 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);
    push("add.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    push("add.aluwb", ov(4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();

    // CMP sets Z, no register write
    start("cmp", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    push("cmp.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 2'b00, 0));
    push("cmp.aluwb", ov(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();
    check4("cmp_flags", Flags, 4'b0100);

    start("addeq", 4'h0, 2'b00, 6'b001000, 4'd2, 4'b0100);
    push("addeq.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    push("addeq.aluwb", ov(4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();

    start("addne", 4'h1, 2'b00, 6'b001000, 4'd2, 4'b0100);
    push("addne.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    push("addne.aluwb", ov(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();

    // ADDS immediate: all four flags load
    start("adds_i", 4'hE, 2'b00, 6'b101001, 4'd3, 4'b0011);
    push("adds_i.execi", ov(4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0));
    push("adds_i.aluwb", ov(4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();
    check4("adds_flags", Flags, 4'b0011);

    // MOVS: only N and Z load, C/V kept
    start("movs", 4'hE, 2'b00, 6'b011011, 4'd4, 4'b1000);
    push("movs.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b100, 2'b00, 0));
    push("movs.aluwb", ov(4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();
    check4("movs_flags", Flags, 4'b1011);

    // ORRNE PC: passes (Z=0), PC destination also writes PC
    start("orr_pc", 4'h1, 2'b00, 6'b011000, 4'd15, 4'b0000);
    push("orr_pc.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b011, 2'b00, 0));
    push("orr_pc.aluwb", ov(4'd8, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();

    // ANDSEQ fails: no write, flags untouched
    start("andseq", 4'h0, 2'b00, 6'b000001, 4'd5, 4'b0100);
    push("andseq.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0));
    push("andseq.aluwb", ov(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();
    check4("andseq_flags", Flags, 4'b1011);

    // Cond=1111 never passes
    start("add_nv", 4'hF, 2'b00, 6'b001000, 4'd1, 4'b0000);
    push("add_nv.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    push("add_nv.aluwb", ov(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();

    // Unsupported cmd (EOR): ADD with no write
    start("eor", 4'hE, 2'b00, 6'b000010, 4'd1, 4'b0000);
    push("eor.execr", ov(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    push("eor.aluwb", ov(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();

    // LDR, U=0
    start("ldr", 4'hE, 2'b01, 6'b010001, 4'd6, 4'b0000);
    push("ldr.memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 3'b001, 2'b00, 0));
    push("ldr.memrd",  ov(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    push("ldr.memwb",  ov(4'd4, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 0));
    drain();
    check4("ldr_imm_regsrc", {ImmSrc, RegSrc}, 4'b0100);

    // LDR PC, U=1
    start("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    push("ldr_pc.memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0));
    push("ldr_pc.memrd",  ov(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    push("ldr_pc.memwb",  ov(4'd4, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 0));
    drain();

    // STR, U=1: MemWrite in exactly one cycle
    start("str", 4'hE, 2'b01, 6'b011000, 4'd7, 4'b0000);
    push("str.memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0));
    push("str.memwr",  ov(4'd5, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    drain();
    check4("str_imm_regsrc", {ImmSrc, RegSrc}, 4'b0110);

    // B
    start("b", 4'hE, 2'b10, 6'b100000, 4'd0, 4'b0000);
    push("b.branch", ov(4'd9, 1, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b10, 0));
    drain();
    check4("b_imm_regsrc", {ImmSrc, RegSrc}, 4'b1001);

    // BEQ with Z=0: walks BRANCH without writing PC
    start("beq", 4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
    push("beq.branch", ov(4'd9, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b10, 0));
    drain();

    // BL
    start("bl", 4'hE, 2'b10, 6'b110000, 4'd0, 4'b0000);
`ifdef MC_CTRL_BL_EN
    push("bl.link", ov(4'd10, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b11, 1));
`endif
    push("bl.branch", ov(4'd9, 1, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b10, 0));
    drain();

    // Op=11: back to FETCH after DECODE
    start("op11", 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
    drain();

    // Reset during MEMRD aborts the load
    start("ldr_rst", 4'hE, 2'b01, 6'b010001, 4'd8, 4'b0000);
    push("ldr_rst.memadr", ov(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 3'b001, 2'b00, 0));
    drain();
    #2;
    check_vec("ldr_rst.memrd", ov(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
    rst_n = 1'b0;
    #1;
    check_vec("rst_in_memrd", rst_v);
    check4("rst_in_memrd_flags", Flags, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start("post_rst", 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
